// File: rtl/cwt_pkg.sv
// Shared definitions for the CWT datapath: default widths, a clog2 helper and the
// signed shift-and-saturate routine used by the accumulator and later stages.
package cwt_pkg;

  localparam int unsigned CwtBits    = 16;
  localparam int unsigned CwtAccBits = 32;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } sat_res_t;

  function automatic int unsigned cwt_clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Arithmetic right shift then clamp into a signed field of 'bits' width.
  function automatic sat_res_t sat_shift(input logic signed [63:0] val,
                                         input int unsigned        shift,
                                         input int unsigned        bits);
    logic signed [63:0] sh;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           res;
    sh    = val >>> shift;
    max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bits - 1));
    if (sh > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (sh < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end else begin
      res.value = sh;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/cwt_complex_accumulator_sat_shift.sv
// Combinational scale-and-saturate of one accumulator component down to the output width.
module cwt_sat_shift
  import cwt_pkg::*;
#(
  parameter int unsigned ACC_BITS = CwtAccBits,
  parameter int unsigned BITS     = CwtBits,
  parameter int unsigned SHIFT    = 0
) (
  input  logic signed [ACC_BITS-1:0] i_val,
  output logic signed [BITS-1:0]     o_val,
  output logic                       o_sat
);

  sat_res_t w_res;
  logic     w_unused_hi;

  always_comb begin
    w_res = sat_shift(64'(i_val), SHIFT, BITS);
  end

  assign o_val = w_res.value[BITS-1:0];
  assign o_sat = w_res.sat;

  // Upper bits are sign copies after clamping; only the low field is meaningful.
  assign w_unused_hi = ^w_res.value[63:BITS];

endmodule

// File: rtl/cwt_complex_accumulator.sv
// Sums TAPS consecutive complex products, then scales/saturates the frame sum onto a
// valid/ready output. Only the final product of a frame can be back-pressured.
module cwt_complex_accumulator
  import cwt_pkg::*;
#(
  parameter int unsigned BITS     = CwtBits,
  parameter int unsigned ACC_BITS = CwtAccBits,
  parameter int unsigned TAPS     = 64,
  parameter int unsigned SHIFT    = 6,
  localparam int unsigned CntW    = cwt_clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] in_r,
  input  logic signed [BITS-1:0] in_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] out_r,
  output logic signed [BITS-1:0] out_i,
  output logic                   out_sat,
  output logic [CntW-1:0]        tap_cnt
);

  logic [CntW-1:0]           r_cnt;
  logic signed [ACC_BITS-1:0] r_acc_r;
  logic signed [ACC_BITS-1:0] r_acc_i;
  logic                      r_out_valid;
  logic signed [BITS-1:0]    r_out_r;
  logic signed [BITS-1:0]    r_out_i;
  logic                      r_out_sat;

  logic                      w_last;
  logic                      w_xfer;
  logic                      w_final;
  logic                      w_out_take;
  logic signed [ACC_BITS-1:0] w_ext_r;
  logic signed [ACC_BITS-1:0] w_ext_i;
  logic signed [ACC_BITS-1:0] w_tot_r;
  logic signed [ACC_BITS-1:0] w_tot_i;
  logic signed [BITS-1:0]    w_res_r;
  logic signed [BITS-1:0]    w_res_i;
  logic                      w_sat_r;
  logic                      w_sat_i;

  assign w_last     = (r_cnt == CntW'(TAPS - 1));
  assign in_ready   = !rst && !(w_last && r_out_valid && !out_ready);
  assign w_xfer     = in_valid && in_ready;
  assign w_final    = w_xfer && w_last;
  assign w_out_take = r_out_valid && out_ready;

  assign w_ext_r = ACC_BITS'(in_r);
  assign w_ext_i = ACC_BITS'(in_i);
  assign w_tot_r = r_acc_r + w_ext_r;
  assign w_tot_i = r_acc_i + w_ext_i;

  cwt_sat_shift #(
    .ACC_BITS (ACC_BITS),
    .BITS     (BITS),
    .SHIFT    (SHIFT)
  ) u_sat_r (
    .i_val (w_tot_r),
    .o_val (w_res_r),
    .o_sat (w_sat_r)
  );

  cwt_sat_shift #(
    .ACC_BITS (ACC_BITS),
    .BITS     (BITS),
    .SHIFT    (SHIFT)
  ) u_sat_i (
    .i_val (w_tot_i),
    .o_val (w_res_i),
    .o_sat (w_sat_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        // Tap 0 overwrites, so frames chain with no clear cycle; final tap leaves acc alone.
        if (!w_last) begin
          r_acc_r <= (r_cnt == '0) ? w_ext_r : w_tot_r;
          r_acc_i <= (r_cnt == '0) ? w_ext_i : w_tot_i;
        end
      end
      if (w_final) begin
        r_out_valid <= 1'b1;
        r_out_r     <= w_res_r;
        r_out_i     <= w_res_i;
        r_out_sat   <= w_sat_r | w_sat_i;
      end else if (w_out_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_sat   = r_out_sat;
  assign tap_cnt   = r_cnt;

endmodule

// File: tb/tb_cwt_complex_accumulator.sv
// Scoreboard bench: instance A (TAPS=4, SHIFT=0) runs directed and random traffic against a
// reference model; instance B (TAPS=64, SHIFT=6) checks full-length frames and scaling.
module tb_cwt_complex_accumulator;

  localparam int unsigned TA = 4;
  localparam int unsigned SA = 0;
  localparam int unsigned TB = 64;
  localparam int unsigned SB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic               a_in_valid = 1'b0;
  logic               a_in_ready;
  logic signed [15:0] a_in_r = '0;
  logic signed [15:0] a_in_i = '0;
  logic               a_out_valid;
  logic               a_out_ready = 1'b0;
  logic signed [15:0] a_out_r;
  logic signed [15:0] a_out_i;
  logic               a_out_sat;
  logic [1:0]         a_tap_cnt;

  logic               b_in_valid = 1'b0;
  logic               b_in_ready;
  logic signed [15:0] b_in_r = '0;
  logic signed [15:0] b_in_i = '0;
  logic               b_out_valid;
  logic               b_out_ready = 1'b1;
  logic signed [15:0] b_out_r;
  logic signed [15:0] b_out_i;
  logic               b_out_sat;
  logic [5:0]         b_tap_cnt;

  cwt_complex_accumulator #(
    .BITS (16), .ACC_BITS (32), .TAPS (TA), .SHIFT (SA)
  ) u_dut_a (
    .clk (clk), .rst (rst),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_r (a_in_r), .in_i (a_in_i),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_r (a_out_r), .out_i (a_out_i),
    .out_sat (a_out_sat), .tap_cnt (a_tap_cnt)
  );

  cwt_complex_accumulator #(
    .BITS (16), .ACC_BITS (32), .TAPS (TB), .SHIFT (SB)
  ) u_dut_b (
    .clk (clk), .rst (rst),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_r (b_in_r), .in_i (b_in_i),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_r (b_out_r), .out_i (b_out_i),
    .out_sat (b_out_sat), .tap_cnt (b_tap_cnt)
  );

  typedef struct {
    longint r;
    longint i;
    bit     sat;
  } res_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  res_t               q[$];
  longint             m_acc_r = 0;
  longint             m_acc_i = 0;
  int                 m_cnt   = 0;
  bit                 hold_v  = 1'b0;
  logic signed [15:0] hold_r;
  logic signed [15:0] hold_i;
  logic               hold_s;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp16(input longint v, output bit s);
    s = 1'b1;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    s = 1'b0;
    return v;
  endfunction

  function automatic res_t ref_res(input longint tr, input longint ti, input int sh);
    res_t e;
    bit   sr;
    bit   si;
    e.r   = clamp16(tr >>> sh, sr);
    e.i   = clamp16(ti >>> sh, si);
    e.sat = sr | si;
    return e;
  endfunction

  // One clock of instance A: drive, check against the model, then advance the model.
  task automatic a_cycle(input bit v, input int r, input int i, input bit ordy);
    res_t e;
    bit   rdy;
    bit   take;
    @(negedge clk);
    a_in_valid  = v;
    a_in_r      = 16'(r);
    a_in_i      = 16'(i);
    a_out_ready = ordy;
    #1;
    rdy  = !(m_cnt == TA - 1 && q.size() > 0 && !ordy);
    take = (q.size() > 0) && ordy;
    check_eq("a_out_valid", a_out_valid, q.size() > 0);
    check_eq("a_tap_cnt", a_tap_cnt, m_cnt);
    check_eq("a_in_ready", a_in_ready, rdy);
    if (hold_v) begin
      check_eq("a_hold_r", a_out_r, hold_r);
      check_eq("a_hold_i", a_out_i, hold_i);
      check_eq("a_hold_sat", a_out_sat, hold_s);
    end
    hold_v = a_out_valid && !ordy;
    hold_r = a_out_r;
    hold_i = a_out_i;
    hold_s = a_out_sat;
    if (take) begin
      e = q.pop_front();
      check_eq("a_out_r", a_out_r, e.r);
      check_eq("a_out_i", a_out_i, e.i);
      check_eq("a_out_sat", a_out_sat, e.sat);
    end
    if (v && rdy) begin
      if (m_cnt == TA - 1) begin
        q.push_back(ref_res(m_acc_r + r, m_acc_i + i, SA));
        m_cnt = 0;
      end else begin
        m_acc_r = (m_cnt == 0) ? longint'(r) : m_acc_r + r;
        m_acc_i = (m_cnt == 0) ? longint'(i) : m_acc_i + i;
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    #1;
    check_eq("a_in_ready_rst", a_in_ready, 0);
    @(negedge clk);
    rst        = 1'b0;
    a_in_valid = 1'b0;
    m_cnt      = 0;
    hold_v     = 1'b0;
    q.delete();
    #1;
    check_eq("a_rst_out_r", a_out_r, 0);
    check_eq("a_rst_out_i", a_out_i, 0);
    check_eq("a_rst_out_sat", a_out_sat, 0);
    check_eq("a_rst_tap_cnt", a_tap_cnt, 0);
  endtask

  // Full TAPS-long frame on instance B; mode 0 is full scale, otherwise random.
  task automatic b_frame(input int mode);
    longint             sr = 0;
    longint             si = 0;
    logic signed [15:0] vr;
    logic signed [15:0] vi;
    res_t               e;
    for (int k = 0; k < int'(TB); k++) begin
      @(negedge clk);
      if (mode == 0) begin
        vr = 16'sh7fff;
        vi = 16'sh8000;
      end else begin
        vr = 16'($urandom);
        vi = 16'($urandom);
      end
      b_in_valid = 1'b1;
      b_in_r     = vr;
      b_in_i     = vi;
      sr += vr;
      si += vi;
      #1;
      check_eq("b_in_ready", b_in_ready, 1);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    e = ref_res(sr, si, SB);
    check_eq("b_out_valid", b_out_valid, 1);
    check_eq("b_out_r", b_out_r, e.r);
    check_eq("b_out_i", b_out_i, e.i);
    check_eq("b_out_sat", b_out_sat, e.sat);
    check_eq("b_tap_cnt", b_tap_cnt, 0);
    @(negedge clk);
    #1;
    check_eq("b_out_valid_drop", b_out_valid, 0);
  endtask

  initial begin
    logic signed [15:0] rr;
    logic signed [15:0] ri;
    do_reset();

    // Basic sum -> (10,-10)
    for (int k = 1; k <= 4; k++) a_cycle(1'b1, k, -k, 1'b1);
    repeat (3) a_cycle(1'b0, 0, 0, 1'b1);

    // Back-to-back frames -> (400,200) twice, no bubbles
    repeat (8) a_cycle(1'b1, 100, 50, 1'b1);
    repeat (2) a_cycle(1'b0, 0, 0, 1'b1);

    // Saturation at both rails
    repeat (4) a_cycle(1'b1, 32767, -32768, 1'b1);
    repeat (4) a_cycle(1'b1, -32768, 32767, 1'b1);
    repeat (2) a_cycle(1'b0, 0, 0, 1'b1);

    // Backpressure on the final product of the next frame
    for (int k = 1; k <= 4; k++) a_cycle(1'b1, k, 2 * k, 1'b0);
    for (int k = 5; k <= 7; k++) a_cycle(1'b1, k, -k, 1'b0);
    repeat (3) a_cycle(1'b1, 8, -8, 1'b0);
    a_cycle(1'b1, 8, -8, 1'b1);
    a_cycle(1'b0, 0, 0, 1'b0);
    a_cycle(1'b0, 0, 0, 1'b1);
    a_cycle(1'b0, 0, 0, 1'b1);

    // Reset mid-frame discards the partial sum
    a_cycle(1'b1, 500, 500, 1'b1);
    a_cycle(1'b1, 500, 500, 1'b1);
    do_reset();
    repeat (4) a_cycle(1'b1, 1, 1, 1'b1);
    repeat (2) a_cycle(1'b0, 0, 0, 1'b1);

    // Instance B: full-length frames with SHIFT=6
    b_frame(0);
    b_frame(1);
    b_frame(1);

    // Random traffic with gaps on both sides
    repeat (6000) begin
      rr = 16'($urandom);
      ri = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rr = rr >>> 4;
        ri = ri >>> 4;
      end
      a_cycle($urandom_range(0, 3) != 0, int'(rr), int'(ri), $urandom_range(0, 9) < 7);
    end
    repeat (6) a_cycle(1'b0, 0, 0, 1'b1);
    check_eq("a_queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cwt_complex_accumulator.md
Name: cwt_complex_accumulator

Overview:
Downstream stage of the CWT complex multiplier. It consumes the stream of signed complex products (signal sample × wavelet coefficient) and sums TAPS consecutive products into one wavelet coefficient. It scales and saturates the sum back to BITS and presents it on a valid/ready output. One instance serves one scale of the transform.

Parameters:
BITS, 16, width of each real/imag input and output word (signed two's complement)
ACC_BITS, 32, internal accumulator width per component; must be >= BITS + clog2(TAPS)
TAPS, 64, products summed per output; must be >= 2
SHIFT, 6, arithmetic right shift applied to the final sum before saturation; must be 0..ACC_BITS-BITS

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  product word valid
in_ready  out  1  block accepts product this cycle
in_r  in  BITS  product real part, signed
in_i  in  BITS  product imaginary part, signed
out_valid  out  1  result word valid
out_ready  in  1  consumer accepts result this cycle
out_r  out  BITS  scaled, saturated real sum
out_i  out  BITS  scaled, saturated imaginary sum
out_sat  out  1  set if either component saturated in this result
tap_cnt  out  clog2(TAPS)  index of next product expected (debug/status)

Behaviour:
- Reset (rst=1 at clock edge):
  - acc_r, acc_i, tap_cnt, out_valid, out_r, out_i and out_sat all go to 0.
  - in_ready is 0 during the reset cycle and 1 from the first cycle after.
  - Reset mid-frame discards the partial sum and any held result; no output is produced for it.
- Input transfer: occurs when in_valid && in_ready.
  - Inputs are sign-extended to ACC_BITS.
  - tap_cnt increments by 1 per transfer and wraps from TAPS-1 to 0.
- Non-final transfer (tap_cnt != TAPS-1):
  - If tap_cnt==0, acc <= sext(in); otherwise acc <= acc + sext(in).
  - No separate clear cycle is used, so back-to-back frames run with zero bubbles.
- Final transfer (tap_cnt == TAPS-1):
  - total = acc + sext(in).
  - The output register loads sat(total >>> SHIFT) per component; out_sat is the OR of both components' saturation.
  - out_valid <= 1 on the next edge, so latency from the final input to out_valid is 1 cycle.
  - The accumulator is not updated; the next transfer (tap_cnt==0) overwrites it.
- Saturation: the shifted value is clamped to [-2^(BITS-1), 2^(BITS-1)-1]. Accumulator wrap is impossible by the ACC_BITS constraint.
- Output handshake:
  - out_valid stays high and out_r/out_i/out_sat stay stable until out_valid && out_ready.
  - On that cycle out_valid drops, unless a new final transfer happens in the same cycle; then the register reloads and out_valid stays 1.
- Backpressure: in_ready = !(tap_cnt==TAPS-1 && out_valid && !out_ready). Only the final product of a frame stalls, and only while the previous result is unconsumed.
- in_ready does not depend combinationally on in_valid. It depends on out_ready only as stated above.
- Simultaneous final transfer and output acceptance in the same cycle: both happen; no result is lost or duplicated.
- in_r/in_i are ignored when no transfer occurs.
- No FSM beyond tap_cnt and the out_valid flag; states are ACCUM (out_valid=0) and ACCUM_HOLD (out_valid=1).

Decomposition:
- Shared package cwt_pkg holds BITS/ACC_BITS defaults, a clog2 helper, and a signed saturate-and-shift function reused by later stages.
- One natural sub-module, cwt_sat_shift (combinational: ACC_BITS in -> BITS out + sat flag), instantiated twice, for real and imaginary.

Test Plan:
- Basic sum, TAPS=4, SHIFT=0: inputs (1,-1),(2,-2),(3,-3),(4,-4) on consecutive cycles with out_ready=1 -> one cycle after the 4th, out=(10,-10), out_sat=0, out_valid for exactly 1 cycle.
- Back-to-back frames: TAPS=4, two frames of constant (100,50) streamed with no gaps -> two results (400,200) four cycles apart; in_ready never drops.
- Saturation: TAPS=64, SHIFT=0, all inputs (32767,-32768) -> out=(32767,-32768), out_sat=1. Repeat with SHIFT=6 -> out=(32767,-32768), out_sat=0.
- Backpressure: TAPS=4, out_ready=0 after the first result.
  - The next frame's first 3 products are accepted.
  - in_ready=0 at tap_cnt=3 while out_valid=1; the first result stays stable.
  - Raising out_ready for one cycle accepts it and admits the 4th product in the same cycle; the second result appears on the next edge.
- Reset mid-frame: TAPS=4, send 2 products, assert rst 1 cycle, then send 4 products (1,1) -> only one result, (4,4); tap_cnt=0 after reset.
- Random: 1000 frames of random signed products with random in_valid/out_ready gaps, checked against a reference model. No lost or duplicated results; outputs stable while stalled.
